// File: rtl/fp_series_feeder.sv
// fp_series_feeder: framing stage in front of the pairwise FP32 adder tree.
// Gathers one frame of N sanitized operands over a valid/ready stream,
// replays the frame back-to-back on the tree's load port, then waits for
// the tree to settle before pulsing sum_valid.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FILL  | accepting operands into the frame buffer (in_ready = 1)
// S_BURST | replaying buffer words 0..N-1, one per clock, no stall
// S_WAIT  | holding off while the tree settles; sum_valid on last cycle
module fp_series_feeder #(
  parameter int N      = 8,
  parameter int SETTLE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_first,
  output logic        out_last,
  output logic        sum_valid,
  output logic        nan_seen,
  output logic        denorm_seen,
  output logic        busy
);

  localparam int CW = $clog2(N) + 1;
  localparam int IW = $clog2(N);
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {S_FILL, S_BURST, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   fill_cnt_q, fill_cnt_d;
  logic [IW-1:0]   rd_idx_q, rd_idx_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic            nan_q, nan_d;
  logic            den_q, den_d;
  logic [31:0]     mem_q [N];

  logic [7:0]      in_exp;
  logic [22:0]     in_man;
  logic            in_is_nan;
  logic            in_is_den;
  logic [31:0]     in_san;
  logic            accept;
  logic            flush_eff;
  logic [CW-1:0]   fill_next;

  // Operand sanitization: quiet NaN canonicalization and denormal flush to signed zero
  always_comb begin
    in_exp    = in_data[30:23];
    in_man    = in_data[22:0];
    in_is_nan = (in_exp == 8'hFF) && (in_man != 23'd0);
    in_is_den = (in_exp == 8'h00) && (in_man != 23'd0);
    if (in_is_nan) begin
      in_san = 32'h7FC0_0000;
    end else if (in_is_den) begin
      in_san = {in_data[31], 31'd0};
    end else begin
      in_san = in_data;
    end
  end

  // Accept/flush qualification; a flush is only meaningful once the frame holds a word
  always_comb begin
    accept    = in_valid && (state_q == S_FILL);
    fill_next = fill_cnt_q + (accept ? CW'(1) : CW'(0));
    flush_eff = flush && (state_q == S_FILL) && (fill_next != CW'(0));
  end

  // Frame buffer: store accepted word, then zero every slot beyond it on flush
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (accept && (fill_cnt_q == CW'(i))) begin
        mem_q[i] <= in_san;
      end else if (flush_eff && (CW'(i) >= fill_next)) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end
  end

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FILL;
      fill_cnt_q <= '0;
      rd_idx_q   <= '0;
      settle_q   <= '0;
      nan_q      <= 1'b0;
      den_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      rd_idx_q   <= rd_idx_d;
      settle_q   <= settle_d;
      nan_q      <= nan_d;
      den_q      <= den_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    rd_idx_d   = rd_idx_q;
    settle_d   = settle_q;
    nan_d      = nan_q;
    den_d      = den_q;
    in_ready   = 1'b0;
    out_data   = 32'h0000_0000;
    out_valid  = 1'b0;
    out_first  = 1'b0;
    out_last   = 1'b0;
    sum_valid  = 1'b0;

    unique case (state_q)
      S_FILL: begin
        in_ready = 1'b1;
        if (accept) begin
          fill_cnt_d = fill_next;
          // first word of a frame restarts the sticky flags
          if (fill_cnt_q == CW'(0)) begin
            nan_d = in_is_nan;
            den_d = in_is_den;
          end else begin
            nan_d = nan_q | in_is_nan;
            den_d = den_q | in_is_den;
          end
        end
        if ((accept && (fill_next == CW'(N))) || flush_eff) begin
          state_d  = S_BURST;
          rd_idx_d = '0;
        end
      end
      S_BURST: begin
        out_valid = 1'b1;
        out_data  = mem_q[rd_idx_q];
        out_first = (rd_idx_q == IW'(0));
        out_last  = (rd_idx_q == IW'(N - 1));
        if (rd_idx_q == IW'(N - 1)) begin
          state_d  = S_WAIT;
          settle_d = SW'(SETTLE);
        end else begin
          rd_idx_d = rd_idx_q + IW'(1);
        end
      end
      S_WAIT: begin
        // WAIT spans SETTLE+1 cycles so sum_valid lands N+SETTLE after out_first
        if (settle_q == SW'(0)) begin
          sum_valid  = 1'b1;
          state_d    = S_FILL;
          fill_cnt_d = '0;
          rd_idx_d   = '0;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  assign nan_seen    = nan_q;
  assign denorm_seen = den_q;
  assign busy        = (state_q != S_FILL);

endmodule

// File: tb/tb_fp_series_feeder.sv
// Directed bench for fp_series_feeder: streaming, flush padding,
// sanitization flags, random valid gaps, mid-burst reset, ignored flushes.
module tb_fp_series_feeder;

  localparam int N      = 8;
  localparam int SETTLE = 8;

  typedef logic [31:0] frame_t [N];

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_first;
  logic        out_last;
  logic        sum_valid;
  logic        nan_seen;
  logic        denorm_seen;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  frame_t ramp    = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                      32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
  frame_t padded  = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000,
                      32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
  frame_t san_in  = '{32'h7F80_0001, 32'h0000_0001, 32'h8000_0005, 32'hFF80_0000,
                      32'h7F80_0000, 32'h0000_0000, 32'h8000_0000, 32'h3F80_0000};
  frame_t san_exp = '{32'h7FC0_0000, 32'h0000_0000, 32'h8000_0000, 32'hFF80_0000,
                      32'h7F80_0000, 32'h0000_0000, 32'h8000_0000, 32'h3F80_0000};
  frame_t twos    = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000,
                      32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};

  fp_series_feeder #(.N(N), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_first   (out_first),
    .out_last    (out_last),
    .sum_valid   (sum_valid),
    .nan_seen    (nan_seen),
    .denorm_seen (denorm_seen),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at the sample point of burst word 0; follows the frame to sum_valid.
  task automatic collect_burst(input frame_t exp_w, input logic exp_nan, input logic exp_den,
                               input bit flush_in_wait, input string name);
    int cyc;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_w[k] || out_first !== logic'(k == 0) ||
          out_last !== logic'(k == N - 1) || in_ready !== 1'b0 || busy !== 1'b1 || sum_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s burst[%0d]: valid=%b data=%h first=%b last=%b ready=%b busy=%b sum_valid=%b; want valid=1 data=%h first=%b last=%b ready=0 busy=1 sum_valid=0",
                 name, k, out_valid, out_data, out_first, out_last, in_ready, busy, sum_valid,
                 exp_w[k], k == 0, k == N - 1);
      end
      checks++;
      if (nan_seen !== exp_nan || denorm_seen !== exp_den) begin
        failures++;
        $display("FAIL %s burst flags[%0d]: nan=%b den=%b; want nan=%b den=%b",
                 name, k, nan_seen, denorm_seen, exp_nan, exp_den);
      end
      step();
    end
    cyc = N;
    while (sum_valid !== 1'b1 && cyc < N + SETTLE + 4) begin
      checks++;
      if (out_valid !== 1'b0 || out_first !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b0 ||
          busy !== 1'b1 || nan_seen !== exp_nan || denorm_seen !== exp_den) begin
        failures++;
        $display("FAIL %s wait cycle %0d: valid=%b first=%b last=%b ready=%b busy=%b nan=%b den=%b; want 0 0 0 0 1 %b %b",
                 name, cyc, out_valid, out_first, out_last, in_ready, busy, nan_seen, denorm_seen,
                 exp_nan, exp_den);
      end
      if (flush_in_wait && cyc == N + 2) flush = 1'b1;
      step();
      flush = 1'b0;
      cyc++;
    end
    checks++;
    if (sum_valid !== 1'b1 || cyc != N + SETTLE) begin
      failures++;
      $display("FAIL %s sum_valid latency: sum_valid=%b after %0d cycles; want 1 after %0d cycles",
               name, sum_valid, cyc, N + SETTLE);
    end
    step();
    checks++;
    if (sum_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s after sum: sum_valid=%b ready=%b busy=%b; want 0 1 0",
               name, sum_valid, in_ready, busy);
    end
  endtask

  // Streams `count` words with in_valid held high; leaves in_valid asserted.
  task automatic stream_words(input frame_t w, input int count, input string name);
    for (int i = 0; i < count; i++) begin
      in_data  = w[i];
      in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s ready before word %0d: got %b want 1", name, i, in_ready);
      end
      step();
    end
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || out_data !== 32'd0 || out_valid !== 1'b0 || out_first !== 1'b0 ||
        out_last !== 1'b0 || sum_valid !== 1'b0 || nan_seen !== 1'b0 || denorm_seen !== 1'b0 ||
        busy !== 1'b0) begin
      failures++;
      $display("FAIL reset outputs: ready=%b data=%h valid=%b first=%b last=%b sum=%b nan=%b den=%b busy=%b; want ready=1 rest 0",
               in_ready, out_data, out_valid, out_first, out_last, sum_valid, nan_seen, denorm_seen, busy);
    end
  endtask

  task automatic test_stream(input string name);
    stream_words(ramp, N, name);
    in_data = 32'h4110_0000;
    checks++;
    if (in_ready !== 1'b0 || out_first !== 1'b1) begin
      failures++;
      $display("FAIL %s first burst cycle: ready=%b first=%b; want ready=0 first=1", name, in_ready, out_first);
    end
    collect_burst(ramp, 1'b0, 1'b0, 1'b0, name);
    in_valid = 1'b0;
  endtask

  task automatic test_flush_partial();
    padded[0] = 32'h3F80_0000;
    stream_words(padded, 3, "flush_partial");
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    collect_burst(padded, 1'b0, 1'b0, 1'b0, "flush_partial");
  endtask

  task automatic test_sanitize();
    for (int i = 0; i < N; i++) begin
      in_data  = san_in[i];
      in_valid = 1'b1;
      step();
      if (i == 0) begin
        checks++;
        if (nan_seen !== 1'b1 || denorm_seen !== 1'b0) begin
          failures++;
          $display("FAIL sanitize flags after NaN: nan=%b den=%b; want 1 0", nan_seen, denorm_seen);
        end
      end else if (i == 1) begin
        checks++;
        if (nan_seen !== 1'b1 || denorm_seen !== 1'b1) begin
          failures++;
          $display("FAIL sanitize flags after denormal: nan=%b den=%b; want 1 1", nan_seen, denorm_seen);
        end
      end
    end
    in_valid = 1'b0;
    collect_burst(san_exp, 1'b1, 1'b1, 1'b0, "sanitize");
  endtask

  task automatic test_random_valid();
    int  accepts;
    int  cyc;
    bit  acc_now;
    for (int f = 0; f < 2; f++) begin
      accepts = 0;
      cyc     = 0;
      in_data = 32'h4000_0000;
      while (out_valid !== 1'b1 && cyc < 300) begin
        in_valid = logic'($urandom_range(0, 1));
        acc_now  = (in_valid === 1'b1) && (in_ready === 1'b1);
        step();
        if (acc_now) begin
          accepts++;
          if (accepts == 1) begin
            checks++;
            if (nan_seen !== 1'b0 || denorm_seen !== 1'b0) begin
              failures++;
              $display("FAIL random frame %0d flags after first accept: nan=%b den=%b; want 0 0",
                       f, nan_seen, denorm_seen);
            end
          end
        end
        cyc++;
      end
      in_valid = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || accepts != N) begin
        failures++;
        $display("FAIL random frame %0d accepts: out_valid=%b accepts=%0d; want 1 and %0d",
                 f, out_valid, accepts, N);
      end
      collect_burst(twos, 1'b0, 1'b0, f == 1, "random_valid");
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_burst();
    stream_words(ramp, N, "reset_mid_burst");
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== ramp[4]) begin
      failures++;
      $display("FAIL reset_mid_burst index 4: valid=%b data=%h; want 1 %h", out_valid, out_data, ramp[4]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_data !== 32'd0 || out_valid !== 1'b0 || out_first !== 1'b0 ||
        out_last !== 1'b0 || sum_valid !== 1'b0 || nan_seen !== 1'b0 || denorm_seen !== 1'b0 ||
        busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_burst outputs: ready=%b data=%h valid=%b first=%b last=%b sum=%b busy=%b; want ready=1 rest 0",
               in_ready, out_data, out_valid, out_first, out_last, sum_valid, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < N + SETTLE + 4; k++) begin
      step();
      checks++;
      if (sum_valid !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_burst idle cycle %0d: sum=%b valid=%b busy=%b; want 0 0 0",
                 k, sum_valid, out_valid, busy);
      end
    end
  endtask

  task automatic test_flush_ignored();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_empty: busy=%b valid=%b ready=%b; want 0 0 1", busy, out_valid, in_ready);
    end
    stream_words(ramp, N, "flush_ignored");
    in_valid = 1'b0;
    collect_burst(ramp, 1'b0, 1'b0, 1'b1, "flush_in_wait");
  endtask

  initial begin
    reset    = 1'b1;
    in_data  = 32'd0;
    in_valid = 1'b0;
    flush    = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    step();
    test_stream("stream");
    test_flush_partial();
    test_sanitize();
    test_random_valid();
    test_reset_mid_burst();
    test_stream("stream_after_reset");
    test_flush_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_series_feeder.md
Name: fp_series_feeder

Overview:
- Upstream framing stage for the pairwise FP32 adder tree (fp_series_add).
- Accepts IEEE-754 single-precision operands over a valid/ready stream, sanitizes them, and buffers one frame of N words.
- Replays the frame back-to-back, one word per clock, on the tree's load port, then holds off for the tree's settle time before signalling that the sum is valid.
- Provides the flow control that the tree's free-running load port lacks.

Parameters:
- N, 8, operands per frame; power of two, >= 2; must equal the downstream tree's N.
- SETTLE, 8, cycles to wait after the last burst word before pulsing sum_valid.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_data  in  32  FP32 operand
- in_valid  in  1  in_data is valid
- in_ready  out  1  feeder accepts in_data this cycle
- flush  in  1  one-cycle pulse: close the current partial frame, padding with +0.0
- out_data  out  32  sanitized operand to the tree's data port
- out_valid  out  1  out_data is a frame word
- out_first  out  1  out_data is frame word 0
- out_last  out  1  out_data is frame word N-1
- sum_valid  out  1  one-cycle pulse: downstream sum_out may be sampled
- nan_seen  out  1  sticky per frame: a NaN operand was accepted
- denorm_seen  out  1  sticky per frame: a denormal was flushed
- busy  out  1  state != FILL

Behaviour:
- Reset (async, immediate):
  - state = FILL, fill count = 0, read index = 0, settle count = 0.
  - All outputs are 0 except in_ready = 1.
  - The buffer contents are don't-care.
- Sanitization (combinational on accept, stored in the buffer):
  - NaN (exp = 0xFF, mantissa != 0) -> 0x7FC00000; sets nan_seen.
  - Denormal (exp = 0, mantissa != 0) -> signed zero {sign, 31'b0}; sets denorm_seen.
  - Inf and zero pass through unchanged.
- Buffer: N x 32 register array, plus fill count of width $clog2(N)+1.
- FILL state:
  - in_ready = 1.
  - Accept when in_valid && in_ready: write buf[fill count], then increment fill count.
  - When the accept makes fill count == N, go to BURST next cycle.
  - flush with fill count > 0: every unwritten entry becomes 0x00000000; go to BURST next cycle.
  - flush and accept in the same cycle: the word is stored first, then the frame is padded.
  - flush with fill count == 0: ignored.
- BURST state:
  - in_ready = 0, out_valid = 1, out_data = buf[read index].
  - read index runs 0..N-1, one word per cycle; no stall.
  - out_first asserts at index 0; out_last asserts at index N-1.
  - After index N-1, go to WAIT.
- WAIT state:
  - Count SETTLE cycles.
  - On the final cycle, pulse sum_valid for exactly one cycle.
  - Then go to FILL with fill count = 0 and read index = 0.
- Sticky flags: both hold through BURST and WAIT, and clear on the first accept of the next frame.
- Latency: the first burst word appears 1 cycle after the Nth accept. sum_valid rises N+SETTLE cycles after out_first.
- No accept occurs while busy; in_valid may stay high and the word is held upstream.
- flush outside FILL: ignored.
- Reset mid-BURST or mid-WAIT: the frame is abandoned and the state returns to FILL on the reset edge. No sum_valid pulse is emitted for the abandoned frame.

Test Plan:
- Reset, then stream 1.0, 2.0, …, 8.0 (0x3F800000 … 0x41000000) with in_valid held high.
  - in_ready drops after the 8th word.
  - out_data replays the same 8 words in order; out_first and out_last mark the ends.
  - sum_valid pulses 16 cycles after out_first; the downstream sum reads 0x42100000 (36.0).
- Send 3 words (1.0, 1.0, 1.0), then pulse flush.
  - Burst is 0x3F800000 x3 followed by 0x00000000 x5.
  - sum_valid pulses as normal.
- Send 0x7F800001 and 0x00000001 within a frame.
  - Burst carries 0x7FC00000 and 0x00000000; nan_seen = 1 and denorm_seen = 1.
  - Both flags clear on the first accept of the next frame.
- Toggle in_valid randomly at 50% with 0x40000000 (2.0) words.
  - Exactly 8 accepts per frame and no word is lost.
  - in_ready = 0 during BURST and WAIT.
- Assert reset at burst index 4.
  - All outputs are zero immediately and in_ready = 1; no sum_valid pulse.
  - The next full frame behaves as in the first scenario.
- Pulse flush with an empty buffer, and pulse flush during WAIT: no state change in either case.
